// File: rtl/lc3_pkg.sv
// Shared LC-3 types for the memory-side responder and its RAM.
package lc3_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Word-addressed 16-bit RAM: synchronous write, registered synchronous read.
// The read register is reset; the array contents are not.
module mem_array
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  word_t                wdata_i,
  output word_t                rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  word_t mem_q [DEPTH];
  word_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read data is held until the next read access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

  // Direct backdoor access for preload and inspection from a bench.
  function automatic void set_word(input logic [ADDR_BITS-1:0] addr, input word_t data);
    mem_q[addr] = data;
  endfunction

  function automatic word_t get_word(input logic [ADDR_BITS-1:0] addr);
    return mem_q[addr];
  endfunction

endmodule

// File: rtl/mem_responder.sv
// LC-3 memory responder: accepts one MAR/MDR request at a time, waits LATENCY
// cycles, then completes it with a single-cycle mem_ready pulse.
module mem_responder
  import lc3_pkg::*;
#(
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready
);

  mem_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  word_t            addr_q;
  word_t            wdata_q;
  logic             ready_q;

  logic  acc_en;
  logic  acc_we;
  word_t acc_addr;
  word_t acc_wdata;

  // LATENCY=1 accesses on the accepting edge, so the live inputs feed the RAM
  // in IDLE; otherwise only the latched copies are used.
  always_comb begin
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == MEM_IDLE) begin
      acc_we    = mem_we;
      acc_addr  = mem_addr;
      acc_wdata = mem_wdata;
      acc_en    = mem_en && (LATENCY == 1);
    end else if (state_q == MEM_WAIT) begin
      acc_en = (cnt_q == CNT_W'(1));
    end
    if (reset) begin
      acc_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          ready_q <= 1'b0;
          if (mem_en) begin
            we_q    <= mem_we;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            cnt_q   <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_q <= MEM_RESP;
              ready_q <= 1'b1;
            end else begin
              state_q <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= MEM_RESP;
            ready_q <= 1'b1;
          end
        end
        MEM_RESP: begin
          state_q <= MEM_IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= MEM_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  if (ADDR_BITS < 16) begin : g_addr_alias
    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[15:ADDR_BITS];
  end

  mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (acc_en),
    .we_i   (acc_we),
    .addr_i (acc_addr[ADDR_BITS-1:0]),
    .wdata_i(acc_wdata),
    .rdata_o(mem_rdata)
  );

  assign mem_ready = ready_q;

endmodule
